// File: rtl/problem1_pkg.sv
// ---------------------------------------------------------------------------
// problem1_pkg
// Shared definitions for the problem1 vector checker: FSM state encoding,
// vector and error-counter widths, the default golden response table and a
// helper that extracts one expected {X,Y,Z} entry from a packed table.
// ---------------------------------------------------------------------------
package problem1_pkg;

    localparam int VEC_W       = 3;   // {A,B,C} and {X,Y,Z} width
    localparam int ERR_W       = 4;   // saturating mismatch counter width
    localparam int MAX_VECTORS = 8;   // 2**VEC_W input combinations

    // Default golden table: X=A, Y=B, Z=A|B for input index {A,B,C}.
    localparam logic [MAX_VECTORS*VEC_W-1:0] GOLDEN_DEFAULT = 24'hFED6C0;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE
    } state_t;

    // Expected {X,Y,Z} for vector index idx; entry i lives at bits [3i+2:3i].
    function automatic logic [VEC_W-1:0] golden_entry(
        input logic [MAX_VECTORS*VEC_W-1:0] tbl,
        input logic [VEC_W-1:0]             idx
    );
        logic [VEC_W-1:0] entry;
        entry = '0;
        for (int k = 0; k < MAX_VECTORS; k++) begin
            if (idx == VEC_W'(k)) begin
                entry = tbl[k*VEC_W +: VEC_W];
            end
        end
        return entry;
    endfunction

endpackage

// File: rtl/problem1_settle_timer.sv
// ---------------------------------------------------------------------------
// problem1_settle_timer
// Loadable up-counter that measures the settle window of each vector.
// 'load' clears the count, 'en' advances it, and 'tc' flags the last settle
// cycle (count == SETTLE_CYCLES-1) so the FSM moves to SAMPLE on that edge.
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears the count
//   load  - clear the count to zero (has priority over en)
//   en    - increment the count
//   tc    - terminal count reached
// ---------------------------------------------------------------------------
module problem1_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = 4;
    // With SETTLE_CYCLES=0 the SETTLE state is never entered, so the
    // terminal value is irrelevant; clamp it to keep the constant legal.
    localparam logic [CNT_W-1:0] TC_VALUE =
        (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == TC_VALUE);

endmodule

// File: rtl/problem1_vector_checker.sv
// ---------------------------------------------------------------------------
// problem1_vector_checker
// Self-test engine for a 3-in/3-out combinational unit. On start it drives
// every vector index 0..NUM_VECTORS-1 onto {A,B,C}, waits SETTLE_CYCLES,
// samples {X,Y,Z} for one cycle and compares it with the golden table.
// Reports pass/fail, a saturating mismatch count and the first failing index.
//
// Ports:
//   clk_in             - clock, rising edge
//   rst_n_in           - asynchronous active-low reset
//   start_in           - begin a run (only looked at in IDLE)
//   A_out/B_out/C_out  - stimulus, bits 2/1/0 of the vector index
//   X_in/Y_in/Z_in     - response from the unit under test
//   busy_out           - run in progress
//   done_out           - one-cycle pulse at the end of a run
//   pass_out           - last completed run had zero mismatches
//   err_count_out      - mismatches in the current/last run (saturates at 15)
//   fail_valid_out     - at least one mismatch recorded
//   first_fail_idx_out - index of the first mismatching vector
// ---------------------------------------------------------------------------
module problem1_vector_checker
    import problem1_pkg::*;
#(
    parameter int                             NUM_VECTORS   = 8,
    parameter int                             SETTLE_CYCLES = 2,
    parameter logic [MAX_VECTORS*VEC_W-1:0]   EXPECTED      = GOLDEN_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    output logic             A_out,
    output logic             B_out,
    output logic             C_out,
    input  logic             X_in,
    input  logic             Y_in,
    input  logic             Z_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             pass_out,
    output logic [ERR_W-1:0] err_count_out,
    output logic             fail_valid_out,
    output logic [VEC_W-1:0] first_fail_idx_out
);

    localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VECTORS - 1);
    // State entered whenever a new vector is put on the outputs.
    localparam state_t VEC_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t           state;
    logic [VEC_W-1:0] idx;        // current vector; also drives {A,B,C}
    logic [VEC_W-1:0] response;
    logic [VEC_W-1:0] golden;
    logic             mismatch;
    logic             is_last;
    logic [ERR_W-1:0] err_next;   // count including this cycle's compare
    logic             timer_load;
    logic             timer_en;
    logic             timer_tc;

    assign {A_out, B_out, C_out} = idx;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        response   = {X_in, Y_in, Z_in};
        golden     = golden_entry(EXPECTED, idx);
        mismatch   = (response != golden);
        is_last    = (idx == LAST_IDX);
        err_next   = err_count_out;
        if (mismatch && (err_count_out != '1)) begin
            err_next = err_count_out + ERR_W'(1);
        end
        timer_load = ((state == IDLE) && start_in) ||
                     ((state == SAMPLE) && !is_last);
        timer_en   = (state == SETTLE);
    end

    problem1_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .load  (timer_load),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state              <= IDLE;
            idx                <= '0;
            busy_out           <= 1'b0;
            done_out           <= 1'b0;
            pass_out           <= 1'b0;
            err_count_out      <= '0;
            fail_valid_out     <= 1'b0;
            first_fail_idx_out <= '0;
        end else begin
            // done_out is a pulse: only the final SAMPLE cycle raises it.
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        idx                <= '0;
                        busy_out           <= 1'b1;
                        pass_out           <= 1'b0;
                        err_count_out      <= '0;
                        fail_valid_out     <= 1'b0;
                        first_fail_idx_out <= '0;
                        state              <= VEC_STATE;
                    end
                end
                SETTLE: begin
                    if (timer_tc) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    err_count_out <= err_next;
                    if (mismatch && !fail_valid_out) begin
                        fail_valid_out     <= 1'b1;
                        first_fail_idx_out <= idx;
                    end
                    if (is_last) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                        pass_out <= (err_next == '0);
                    end else begin
                        idx   <= idx + VEC_W'(1);
                        state <= VEC_STATE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/problem1_vector_checker.md
Name: problem1_vector_checker

Overview:
Synthesizable self-test engine for the 3-input/3-output combinational unit (A,B,C -> X,Y,Z). It drives every input vector in sequence to the unit under test and waits a programmable settle time. It then samples the returned X,Y,Z, compares them against a golden table, and reports pass/fail, the error count and the first failing vector. It sits on the other side of the unit from the stimulus: it is both the driver of A/B/C and the receiver/checker of X/Y/Z.

Parameters:
- NUM_VECTORS, 8: vectors applied, indices 0..NUM_VECTORS-1; legal range 1..8.
- SETTLE_CYCLES, 2: idle cycles between driving a vector and sampling the response; legal range 0..15.
- EXPECTED, 24'hFED6C0: golden table. Bits [3i+2:3i] = expected {X,Y,Z} for input {A,B,C}=i. The default encodes X=A, Y=B, Z=A|B.

Ports:
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  reset, asynchronous, active-low
- start_in  input  1  begin a run; sampled only in IDLE
- A_out  output  1  stimulus bit 2 of the vector index
- B_out  output  1  stimulus bit 1
- C_out  output  1  stimulus bit 0
- X_in  input  1  response from unit under test
- Y_in  input  1  response
- Z_in  input  1  response
- busy_out  output  1  run in progress
- done_out  output  1  one-cycle pulse at end of run
- pass_out  output  1  last completed run had zero mismatches
- err_count_out  output  4  mismatches in current/last run
- fail_valid_out  output  1  at least one mismatch recorded
- first_fail_idx_out  output  3  index of first mismatching vector

Behaviour:
- Reset is asynchronous, active-low, on clk_in. While rst_n_in=0:
  - state=IDLE;
  - A/B/C_out=0; busy_out=0; done_out=0; pass_out=0;
  - err_count_out=0; fail_valid_out=0; first_fail_idx_out=0;
  - vector index=0; settle timer=0.
- FSM states: IDLE, SETTLE, SAMPLE. All outputs are registered.
- IDLE + start_in=1 at an edge:
  - idx<=0, {A,B,C}_out<=3'b000, busy_out<=1;
  - err_count_out<=0, fail_valid_out<=0, first_fail_idx_out<=0, pass_out<=0;
  - timer<=0; next state SETTLE, or SAMPLE directly if SETTLE_CYCLES=0.
- SETTLE: timer increments each cycle. After SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
- SAMPLE (exactly one cycle): compare {X_in,Y_in,Z_in} with EXPECTED[3*idx+:3].
  - On mismatch: err_count_out increments, saturating at 15.
  - On the first mismatch of the run: fail_valid_out<=1 and first_fail_idx_out<=idx.
  - If idx < NUM_VECTORS-1: idx<=idx+1, {A,B,C}_out<=idx+1, timer<=0, next SETTLE (or SAMPLE if SETTLE_CYCLES=0).
  - If idx = NUM_VECTORS-1: next IDLE; busy_out<=0; done_out<=1 for one cycle; pass_out<=(final error count==0), including the current compare.
- Latency: each vector occupies SETTLE_CYCLES+1 cycles. done_out is high in the cycle starting NUM_VECTORS*(SETTLE_CYCLES+1) edges after the start edge (default: 24).
- A/B/C_out hold their value for the whole SETTLE+SAMPLE window of a vector. After a run they hold the last vector (3'b111 by default).
- start_in while busy is ignored; a run is never restarted mid-flight.
- start_in in the same cycle done_out is high: the FSM is already in IDLE, so a new run starts. Results clear at that edge and done_out then falls.
- pass_out, err_count_out, fail_valid_out and first_fail_idx_out hold after a run until the next start or reset.
- Reset mid-run: immediate abort, all outputs to reset values, no done_out pulse.
- X/Y/Z are sampled only in SAMPLE; changes in other cycles have no effect.

Decomposition:
- Shared package problem1_pkg:
  - state enum (IDLE, SETTLE, SAMPLE);
  - VEC_W=3;
  - default golden constant 24'hFED6C0;
  - ERR_W=4.
- One natural sub-module, problem1_settle_timer: loadable up-counter with terminal-count output, instantiated once.

Test Plan:
- Correct behavioural model (X=A, Y=B, Z=A|B), default params, start pulse:
  - A/B/C_out step 000..111, 3 cycles each;
  - done_out pulses 24 edges after start;
  - pass_out=1, err_count_out=0, fail_valid_out=0.
- Model with Z stuck at 0 -> err_count_out=6, fail_valid_out=1, first_fail_idx_out=2, pass_out=0.
- Model with Y inverted only for index 5 -> err_count_out=1, first_fail_idx_out=5, pass_out=0.
- start_in held high through a whole run: exactly one run while busy. Because start_in is still high when IDLE is re-entered, a second run starts immediately after done_out and its results are correct.
- rst_n_in low at cycle 10 of a run:
  - all outputs 0 asynchronously, no done_out pulse;
  - a fresh start afterwards completes with pass_out=1.
- SETTLE_CYCLES=0, NUM_VECTORS=4, correct model -> a new vector every cycle; done_out 4 edges after start; pass_out=1.
